// File: rtl/mem_stage.sv
// MEM stage: drives loads/stores over a req/ack bus, stalls upstream while an
// access is outstanding, and holds the registered MEM/WB pipeline outputs.
module mem_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_in,
    input  logic              MemWrite_in,
    input  logic              MemRead_in,
    input  logic              mem_to_reg_in,
    input  logic              mem_src_in,
    input  logic [4:0]        dest_reg_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_out,
    output logic              bus_err,
    output logic              wb_RegWrite,
    output logic              wb_mem_to_reg,
    output logic [4:0]        wb_dest_reg,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic [ADDR_W-1:0] wb_alu_result
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic mem_op;
    logic is_load;
    logic timeout_hit;
    logic abort;

    // Upstream is frozen during an access, so the EX/MEM fields drive the bus directly.
    assign mem_we    = MemWrite_in;
    assign mem_sel   = mem_src_in;
    assign mem_addr  = mem_addr_in;
    assign mem_wdata = wr_data_in;

    always_comb begin
        mem_op      = MemRead_in | MemWrite_in;
        is_load     = MemRead_in & ~MemWrite_in;
        timeout_hit = (state_reg == WAIT) && (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT));
        mem_req     = ~rst & ((state_reg == IDLE) ? mem_op : 1'b1);
        stall_out   = mem_req & ~mem_ack & ~timeout_hit;
        // An ack on the final allowed cycle still wins over the timeout.
        abort       = timeout_hit & ~mem_ack;
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (mem_op && !mem_ack) begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (mem_ack || timeout_hit) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bus_err       <= 1'b0;
            wb_RegWrite   <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_dest_reg   <= '0;
            wb_mem_data   <= '0;
            wb_alu_result <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bus_err   <= abort;
            if (stall_out) begin
                // Bubble so a multi-cycle access writes back exactly once.
                wb_RegWrite   <= 1'b0;
                wb_mem_to_reg <= 1'b0;
                wb_dest_reg   <= '0;
                wb_mem_data   <= '0;
                wb_alu_result <= '0;
            end else begin
                wb_RegWrite   <= RegWrite_in & ~abort;
                wb_mem_to_reg <= mem_to_reg_in;
                wb_dest_reg   <= dest_reg_in;
                wb_mem_data   <= (is_load && !abort) ? mem_rdata : '0;
                wb_alu_result <= mem_addr_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random instructions, each checked
// against a per-instruction latency model of the bus access.
module tb_mem_stage;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          rst;
    logic          RegWrite_in, MemWrite_in, MemRead_in, mem_to_reg_in, mem_src_in;
    logic [4:0]    dest_reg_in;
    logic [AW-1:0] mem_addr_in;
    logic [DW-1:0] wr_data_in;
    logic          mem_req, mem_we, mem_sel;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          stall_out, bus_err;
    logic          wb_RegWrite, wb_mem_to_reg;
    logic [4:0]    wb_dest_reg;
    logic [DW-1:0] wb_mem_data;
    logic [AW-1:0] wb_alu_result;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .mem_to_reg_in(mem_to_reg_in), .mem_src_in(mem_src_in), .dest_reg_in(dest_reg_in),
        .mem_addr_in(mem_addr_in), .wr_data_in(wr_data_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_out(stall_out), .bus_err(bus_err),
        .wb_RegWrite(wb_RegWrite), .wb_mem_to_reg(wb_mem_to_reg), .wb_dest_reg(wb_dest_reg),
        .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wb_zero(input string tag);
        check({tag, ".wb_RegWrite"}, 64'(wb_RegWrite), 64'd0);
        check({tag, ".wb_mem_to_reg"}, 64'(wb_mem_to_reg), 64'd0);
        check({tag, ".wb_dest_reg"}, 64'(wb_dest_reg), 64'd0);
        check({tag, ".wb_mem_data"}, 64'(wb_mem_data), 64'd0);
        check({tag, ".wb_alu_result"}, 64'(wb_alu_result), 64'd0);
    endtask

    task automatic drive_nop();
        RegWrite_in = 0; MemWrite_in = 0; MemRead_in = 0; mem_to_reg_in = 0; mem_src_in = 0;
        dest_reg_in = '0; mem_addr_in = '0; wr_data_in = '0; mem_ack = 0; mem_rdata = '0;
    endtask

    // One instruction. The bus acks in cycle lat after issue; if lat exceeds TO the
    // access times out in cycle TO. Every stalled cycle must show a bubble.
    task automatic run_op(input string tag, input logic rw, input logic mr, input logic mw,
                          input logic m2r, input logic src, input logic [4:0] dest,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] rdata, input int lat, input logic stray);
        bit done = 0;
        bit is_mem = mr | mw;
        bit acked, timed;
        int c = 0;
        int reqs = 0;
        int stalls = 0;
        while (!done) begin
            @(negedge clk);
            RegWrite_in = rw; MemRead_in = mr; MemWrite_in = mw; mem_to_reg_in = m2r;
            mem_src_in = src; dest_reg_in = dest; mem_addr_in = addr; wr_data_in = wdata;
            acked = is_mem && (c == lat);
            timed = is_mem && (lat > TO) && (c == TO);
            mem_ack   = is_mem ? acked : stray;
            mem_rdata = acked ? rdata : DW'($urandom());
            #1;
            check({tag, ".req"}, 64'(mem_req), 64'(is_mem));
            check({tag, ".stall"}, 64'(stall_out), 64'(is_mem && !acked && !timed));
            if (mem_req) reqs++;
            if (stall_out) stalls++;
            if (is_mem) begin
                check({tag, ".we"}, 64'(mem_we), 64'(mw));
                check({tag, ".sel"}, 64'(mem_sel), 64'(src));
                check({tag, ".addr"}, 64'(mem_addr), 64'(addr));
                check({tag, ".wdata"}, 64'(mem_wdata), 64'(wdata));
            end
            @(posedge clk);
            #1;
            check({tag, ".bus_err"}, 64'(bus_err), 64'(timed));
            if (is_mem && !acked && !timed) begin
                check_wb_zero({tag, ".bubble"});
            end else begin
                done = 1;
                check({tag, ".wb_RegWrite"}, 64'(wb_RegWrite), 64'(rw && !timed));
                check({tag, ".wb_mem_to_reg"}, 64'(wb_mem_to_reg), 64'(m2r));
                check({tag, ".wb_dest_reg"}, 64'(wb_dest_reg), 64'(dest));
                check({tag, ".wb_alu_result"}, 64'(wb_alu_result), 64'(addr));
                check({tag, ".wb_mem_data"}, 64'(wb_mem_data),
                      64'((mr && !mw && !timed) ? rdata : '0));
            end
            c++;
        end
        check({tag, ".req_cycles"}, 64'(reqs), 64'(is_mem ? ((lat > TO ? TO : lat) + 1) : 0));
        check({tag, ".stall_cycles"}, 64'(stalls), 64'(is_mem ? (lat > TO ? TO : lat) : 0));
        $display("op %s: rw=%0d rd=%0d wr=%0d src=%0d dest=%0d addr=0x%0h lat=%0d cycles=%0d",
                 tag, rw, mr, mw, src, dest, addr, lat, c);
    endtask

    initial begin
        drive_nop();
        rst = 1;
        MemRead_in = 1;
        mem_ack = 1;
        #1;
        check("reset.req", 64'(mem_req), 64'd0);
        check("reset.stall", 64'(stall_out), 64'd0);
        check("reset.bus_err", 64'(bus_err), 64'd0);
        check_wb_zero("reset");
        @(negedge clk);
        @(negedge clk);
        drive_nop();
        rst = 0;

        run_op("alu", 1, 0, 0, 0, 0, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 0);
        run_op("load0", 1, 1, 0, 1, 0, 5'd7, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        run_op("store3", 0, 0, 1, 0, 0, 5'd0, 32'h200, 32'hCAFEF00D, 32'h0, 3, 0);
        run_op("timeout", 1, 1, 0, 1, 0, 5'd9, 32'h300, 32'h0, 32'h11111111, 100, 0);
        run_op("after_to", 1, 1, 0, 1, 0, 5'd10, 32'h304, 32'h0, 32'h22222222, 0, 0);

        // Asynchronous reset must clear registered outputs without a clock edge.
        run_op("pre_rst", 1, 0, 0, 0, 0, 5'd21, 32'hABCD, 32'h0, 32'h0, 0, 0);
        rst = 1;
        #1;
        check("async_rst.wb_RegWrite", 64'(wb_RegWrite), 64'd0);
        check("async_rst.wb_dest_reg", 64'(wb_dest_reg), 64'd0);
        check("async_rst.wb_alu_result", 64'(wb_alu_result), 64'd0);
        @(negedge clk);
        rst = 0;

        // Reset in WAIT cycle 2 drops the access.
        @(negedge clk);
        RegWrite_in = 1; MemRead_in = 1; MemWrite_in = 0; mem_to_reg_in = 1; mem_src_in = 0;
        dest_reg_in = 5'd4; mem_addr_in = 32'h500; mem_ack = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("wait2.req", 64'(mem_req), 64'd1);
        check("wait2.stall", 64'(stall_out), 64'd1);
        rst = 1;
        #1;
        check("mid_rst.req", 64'(mem_req), 64'd0);
        check("mid_rst.stall", 64'(stall_out), 64'd0);
        check("mid_rst.bus_err", 64'(bus_err), 64'd0);
        check_wb_zero("mid_rst");
        drive_nop();
        @(posedge clk);
        #1;
        check("mid_rst_edge.bus_err", 64'(bus_err), 64'd0);
        check_wb_zero("mid_rst_edge");
        @(negedge clk);
        rst = 0;
        run_op("post_rst", 1, 1, 0, 1, 0, 5'd6, 32'h504, 32'h0, 32'h0BADF00D, 2, 0);

        run_op("stray_ack", 1, 0, 0, 0, 0, 5'd3, 32'h44, 32'h0, 32'h0, 0, 1);
        run_op("io_load", 1, 1, 0, 1, 1, 5'd12, 32'h8000_0010, 32'h0, 32'h5A5A1234, 2, 0);
        run_op("both_set", 1, 1, 1, 1, 0, 5'd13, 32'h600, 32'h77778888, 32'h99990000, 1, 0);

        for (int i = 0; i < 60; i++) begin
            int kind = $urandom_range(0, 3);
            logic mr = (kind == 1) || (kind == 3);
            logic mw = (kind == 2) || (kind == 3);
            run_op($sformatf("rnd%0d", i), 1'($urandom()), mr, mw, 1'($urandom()),
                   1'($urandom()), 5'($urandom()), AW'($urandom()), DW'($urandom()),
                   DW'($urandom()), $urandom_range(0, 6), 1'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
